// File: rtl/hazard_scoreboard_unit.sv
`default_nettype none
// ==== hazard_scoreboard_unit : forwarding selects, stall/flush control, long-op scoreboard -- rev 1.0 ====
module hazard_scoreboard_unit #(
  parameter int REG_BITS     = 5,
  parameter int FWD_STAGES   = 2,
  parameter int MAX_LAT      = 8,
  parameter int FLUSH_CYCLES = 2,
  parameter int SEL_W        = $clog2(FWD_STAGES+2)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           id_valid,
  input  logic [REG_BITS-1:0]            id_rs1,
  input  logic [REG_BITS-1:0]            id_rs2,
  input  logic                           id_use_rs1,
  input  logic                           id_use_rs2,
  input  logic                           ex_valid,
  input  logic [REG_BITS-1:0]            ex_rd,
  input  logic                           ex_wr_en,
  input  logic                           ex_is_load,
  input  logic [FWD_STAGES*REG_BITS-1:0] fwd_rd,
  input  logic [FWD_STAGES-1:0]          fwd_wr_en,
  input  logic [FWD_STAGES-1:0]          fwd_ready,
  input  logic                           lo_issue,
  input  logic [REG_BITS-1:0]            lo_rd,
  input  logic [$clog2(MAX_LAT+1)-1:0]   lo_latency,
  input  logic                           br_mispredict,
  output logic [SEL_W-1:0]               fwd_sel_a,
  output logic [SEL_W-1:0]               fwd_sel_b,
  output logic                           stall,
  output logic                           flush,
  output logic                           lo_busy,
  output logic                           lo_wb,
  output logic                           proto_err
);

  localparam int CNT_W = $clog2(MAX_LAT+1);
  localparam int FL_W  = $clog2(FLUSH_CYCLES+2);

  logic [CNT_W-1:0]    lo_cnt, lo_cnt_n;
  logic [REG_BITS-1:0] lo_rd_q, lo_rd_n;
  logic [FL_W-1:0]     flush_cnt, flush_cnt_n;
  logic                err_q, err_n;
  logic                flushing, lo_active, lo_last;
  logic [SEL_W:0]      res_a, res_b;
  logic                haz_a, haz_b;

  assign flushing  = (flush_cnt != '0);
  assign lo_active = (lo_cnt != '0);
  assign lo_last   = (lo_cnt == CNT_W'(1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      lo_cnt    <= '0;
      lo_rd_q   <= '0;
      flush_cnt <= '0;
      err_q     <= 1'b0;
    end else begin
      lo_cnt    <= lo_cnt_n;
      lo_rd_q   <= lo_rd_n;
      flush_cnt <= flush_cnt_n;
      err_q     <= err_n;
    end
  end

  // Next-state: issue is only accepted from IDLE; wrong-path issues are silently dropped
  always_comb begin
    lo_cnt_n    = lo_cnt;
    lo_rd_n     = lo_rd_q;
    err_n       = err_q;
    flush_cnt_n = flush_cnt;
    if (lo_active) lo_cnt_n = lo_cnt - CNT_W'(1);
    if (lo_issue && !flushing) begin
      if (lo_active) begin
        err_n = 1'b1;
      end else begin
        lo_rd_n = lo_rd;
        if (lo_latency > CNT_W'(MAX_LAT)) begin
          lo_cnt_n = CNT_W'(MAX_LAT);
          err_n    = 1'b1;
        end else if (lo_latency == '0) begin
          lo_cnt_n = CNT_W'(1);
        end else begin
          lo_cnt_n = lo_latency;
        end
      end
    end
    if (br_mispredict)  flush_cnt_n = FL_W'(FLUSH_CYCLES);
    else if (flushing)  flush_cnt_n = flush_cnt - FL_W'(1);
  end

  // Returns {winning stage not ready, select}; scanning down lets the nearest stage win
  function automatic logic [SEL_W:0] resolve(input logic [REG_BITS-1:0] rs);
    logic [SEL_W-1:0] sel;
    logic             nr;
    sel = '0;
    nr  = 1'b0;
    if (rs != '0) begin
      for (int k = FWD_STAGES; k >= 1; k--) begin
        if (fwd_wr_en[k-1] && (fwd_rd[k*REG_BITS-1 -: REG_BITS] == rs)) begin
          sel = SEL_W'(k);
          nr  = !fwd_ready[k-1];
        end
      end
      if ((sel == '0) && lo_last && (lo_rd_q == rs)) sel = SEL_W'(FWD_STAGES+1);
    end
    return {nr, sel};
  endfunction

  function automatic logic hazard(input logic [REG_BITS-1:0] rs, input logic nr);
    return (rs != '0) &&
           ((ex_valid && ex_is_load && ex_wr_en && (ex_rd == rs)) ||
            nr ||
            (lo_active && (lo_rd_q == rs) && !lo_last) ||
            (lo_active && lo_issue));
  endfunction

  // Outputs
  always_comb begin
    res_a     = resolve(id_rs1);
    res_b     = resolve(id_rs2);
    haz_a     = id_use_rs1 && hazard(id_rs1, res_a[SEL_W]);
    haz_b     = id_use_rs2 && hazard(id_rs2, res_b[SEL_W]);
    fwd_sel_a = rst ? '0 : res_a[SEL_W-1:0];
    fwd_sel_b = rst ? '0 : res_b[SEL_W-1:0];
    stall     = !rst && !flushing && id_valid && (haz_a || haz_b);
    flush     = !rst && flushing;
    lo_busy   = !rst && lo_active;
    lo_wb     = !rst && lo_last;
    proto_err = err_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard_unit.sv
`default_nettype none
// ==== tb_hazard_scoreboard_unit : directed vector table plus multi-cycle sequences -- rev 1.0 ====
module tb_hazard_scoreboard_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, id_use_rs1, id_use_rs2;
  logic [4:0] id_rs1, id_rs2;
  logic       ex_valid, ex_wr_en, ex_is_load;
  logic [4:0] ex_rd;
  logic [9:0] fwd_rd;
  logic [1:0] fwd_wr_en, fwd_ready;
  logic       lo_issue;
  logic [4:0] lo_rd;
  logic [3:0] lo_latency;
  logic       br_mispredict;
  logic [1:0] fwd_sel_a, fwd_sel_b;
  logic       stall, flush, lo_busy, lo_wb, proto_err;

  int tests = 0;
  int fails = 0;

  hazard_scoreboard_unit dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_wr_en(ex_wr_en), .ex_is_load(ex_is_load),
    .fwd_rd(fwd_rd), .fwd_wr_en(fwd_wr_en), .fwd_ready(fwd_ready),
    .lo_issue(lo_issue), .lo_rd(lo_rd), .lo_latency(lo_latency),
    .br_mispredict(br_mispredict),
    .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b), .stall(stall), .flush(flush),
    .lo_busy(lo_busy), .lo_wb(lo_wb), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       idv;
    logic [4:0] rs1, rs2;
    logic       u1, u2;
    logic       exv, ld, exwr;
    logic [4:0] exrd;
    logic [4:0] frd2, frd1;
    logic [1:0] fwe, frdy;
    logic [1:0] esa, esb;
    logic       est;
  } vec_t;

  function automatic vec_t mk(string nm, logic idv, logic [4:0] rs1, logic u1, logic [4:0] rs2,
                              logic u2, logic exv, logic ld, logic exwr, logic [4:0] exrd,
                              logic [4:0] frd2, logic [4:0] frd1, logic [1:0] fwe,
                              logic [1:0] frdy, logic [1:0] esa, logic [1:0] esb, logic est);
    vec_t v;
    v.name = nm; v.idv = idv; v.rs1 = rs1; v.u1 = u1; v.rs2 = rs2; v.u2 = u2;
    v.exv = exv; v.ld = ld; v.exwr = exwr; v.exrd = exrd; v.frd2 = frd2; v.frd1 = frd1;
    v.fwe = fwe; v.frdy = frdy; v.esa = esa; v.esb = esb; v.est = est;
    return v;
  endfunction

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp_v);
    tests++;
    if (act !== exp_v) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp_v);
    end
  endtask

  task automatic clear_inputs();
    id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    ex_valid = 1'b0; ex_rd = '0; ex_wr_en = 1'b0; ex_is_load = 1'b0;
    fwd_rd = '0; fwd_wr_en = '0; fwd_ready = '0;
    lo_issue = 1'b0; lo_rd = '0; lo_latency = '0; br_mispredict = 1'b0;
  endtask

  task automatic apply(input vec_t v);
    id_valid = v.idv; id_rs1 = v.rs1; id_rs2 = v.rs2; id_use_rs1 = v.u1; id_use_rs2 = v.u2;
    ex_valid = v.exv; ex_is_load = v.ld; ex_wr_en = v.exwr; ex_rd = v.exrd;
    fwd_rd = {v.frd2, v.frd1}; fwd_wr_en = v.fwe; fwd_ready = v.frdy;
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1; clear_inputs();
    @(negedge clk); rst = 1'b0;
  endtask

  vec_t vecs[12];

  initial begin
    //            name        idv rs1 u1 rs2 u2 exv ld wr exrd f2 f1 fwe    frdy   sa sb st
    vecs[0]  = mk("alu_fwd",   1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 5, 2'b01, 2'b01, 1, 0, 0);
    vecs[1]  = mk("x0_nofwd",  1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 0, 0, 0);
    vecs[2]  = mk("prio_s1",   1, 0, 0, 7, 1, 0, 0, 0, 0, 7, 7, 2'b11, 2'b11, 0, 1, 0);
    vecs[3]  = mk("prio_s2",   1, 0, 0, 7, 1, 0, 0, 0, 0, 7, 7, 2'b10, 2'b11, 0, 2, 0);
    vecs[4]  = mk("load_use",  1, 6, 1, 0, 0, 1, 1, 1, 6, 0, 0, 2'b00, 2'b00, 0, 0, 1);
    vecs[5]  = mk("lu_unused", 1, 6, 0, 0, 0, 1, 1, 1, 6, 0, 0, 2'b00, 2'b00, 0, 0, 0);
    vecs[6]  = mk("lu_novalid",0, 6, 1, 0, 0, 1, 1, 1, 6, 0, 0, 2'b00, 2'b00, 0, 0, 0);
    vecs[7]  = mk("not_ready", 1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 5, 2'b01, 2'b00, 1, 0, 1);
    vecs[8]  = mk("s1_rdy_win",1, 0, 0, 3, 1, 0, 0, 0, 0, 3, 3, 2'b11, 2'b01, 0, 1, 0);
    vecs[9]  = mk("two_ops",   1, 4, 1, 8, 1, 0, 0, 0, 0, 8, 4, 2'b11, 2'b11, 1, 2, 0);
    vecs[10] = mk("ld_nowr",   1, 6, 1, 0, 0, 1, 1, 0, 6, 0, 0, 2'b00, 2'b00, 0, 0, 0);
    vecs[11] = mk("unused_nr", 1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 5, 2'b01, 2'b00, 1, 0, 0);

    rst = 1'b1;
    clear_inputs();
    // Outputs held low during reset even with a forwarding match, a load-use and requests pending
    @(negedge clk);
    apply(vecs[4]); fwd_rd = {5'd0, 5'd6}; fwd_wr_en = 2'b01;
    lo_issue = 1'b1; lo_rd = 5'd6; lo_latency = 4'd1; br_mispredict = 1'b1;
    #2;
    check("rst_sel_a", 8'(fwd_sel_a), 8'd0);
    check("rst_stall", 8'(stall), 8'd0);
    @(negedge clk); clear_inputs(); rst = 1'b0;
    #2;
    check("rst_lo_busy", 8'(lo_busy), 8'd0);
    check("rst_flush", 8'(flush), 8'd0);
    check("rst_proto_err", 8'(proto_err), 8'd0);

    for (int i = 0; i < 12; i++) begin
      @(negedge clk); apply(vecs[i]); #2;
      check({vecs[i].name, ".sel_a"}, 8'(fwd_sel_a), 8'(vecs[i].esa));
      check({vecs[i].name, ".sel_b"}, 8'(fwd_sel_b), 8'(vecs[i].esb));
      check({vecs[i].name, ".stall"}, 8'(stall), 8'(vecs[i].est));
    end

    // Load-use resolves next cycle through stage 1
    @(negedge clk); apply(vecs[4]); #2;
    check("lu_seq_c0_stall", 8'(stall), 8'd1);
    @(negedge clk); clear_inputs();
    id_valid = 1; id_rs1 = 6; id_use_rs1 = 1; fwd_rd = {5'd0, 5'd6}; fwd_wr_en = 2'b01; fwd_ready = 2'b01;
    #2;
    check("lu_seq_c1_stall", 8'(stall), 8'd0);
    check("lu_seq_c1_sel_a", 8'(fwd_sel_a), 8'd1);

    // Long op rd=9 latency 3, dependent rs2 held, second issue in busy cycle 1
    @(negedge clk); clear_inputs();
    id_valid = 1; id_rs2 = 9; id_use_rs2 = 1; lo_issue = 1; lo_rd = 9; lo_latency = 3;
    #2;
    check("lo_c0_stall", 8'(stall), 8'd0);
    @(negedge clk); lo_rd = 12; lo_latency = 2; #2;
    check("lo_c1_busy", 8'(lo_busy), 8'd1);
    check("lo_c1_stall", 8'(stall), 8'd1);
    @(negedge clk); lo_issue = 0; #2;
    check("lo_c2_stall", 8'(stall), 8'd1);
    check("lo_c2_wb", 8'(lo_wb), 8'd0);
    check("lo_c2_err", 8'(proto_err), 8'd1);
    @(negedge clk); #2;
    check("lo_c3_wb", 8'(lo_wb), 8'd1);
    check("lo_c3_sel_b", 8'(fwd_sel_b), 8'd3);
    check("lo_c3_stall", 8'(stall), 8'd0);
    @(negedge clk); #2;
    check("lo_c4_busy", 8'(lo_busy), 8'd0);
    check("lo_c4_sel_b", 8'(fwd_sel_b), 8'd0);
    check("lo_c4_err_sticky", 8'(proto_err), 8'd1);
    do_reset(); #2;
    check("err_cleared", 8'(proto_err), 8'd0);

    // Latency 0 acts as 1; issue colliding with lo_wb is dropped and flagged
    @(negedge clk); lo_issue = 1; lo_rd = 4; lo_latency = 0; #2;
    @(negedge clk); lo_rd = 5; lo_latency = 2; #2;
    check("lat0_wb", 8'(lo_wb), 8'd1);
    @(negedge clk); lo_issue = 0; #2;
    check("collide_busy", 8'(lo_busy), 8'd0);
    check("collide_err", 8'(proto_err), 8'd1);
    do_reset();

    // Over-range latency saturates to MAX_LAT=8 and flags
    @(negedge clk); lo_issue = 1; lo_rd = 2; lo_latency = 12; #2;
    @(negedge clk); lo_issue = 0; #2;
    check("sat_err", 8'(proto_err), 8'd1);
    for (int c = 2; c <= 7; c++) begin
      @(negedge clk); #2;
    end
    check("sat_c7_wb", 8'(lo_wb), 8'd0);
    @(negedge clk); #2;
    check("sat_c8_wb", 8'(lo_wb), 8'd1);
    do_reset();

    // Flush window; stall masked and wrong-path issue ignored while flushing
    @(negedge clk); br_mispredict = 1; #2;
    check("fl_c0", 8'(flush), 8'd0);
    @(negedge clk); br_mispredict = 0; apply(vecs[4]);
    lo_issue = 1; lo_rd = 3; lo_latency = 2; #2;
    check("fl_c1", 8'(flush), 8'd1);
    check("fl_c1_stall", 8'(stall), 8'd0);
    @(negedge clk); lo_issue = 0; #2;
    check("fl_c2", 8'(flush), 8'd1);
    check("fl_c2_busy", 8'(lo_busy), 8'd0);
    @(negedge clk); #2;
    check("fl_c3", 8'(flush), 8'd0);
    check("fl_c3_stall", 8'(stall), 8'd1);
    check("fl_c3_err", 8'(proto_err), 8'd0);
    @(negedge clk); clear_inputs(); br_mispredict = 1; #2;
    @(negedge clk); #2;
    check("rf_c1", 8'(flush), 8'd1);
    @(negedge clk); br_mispredict = 0; #2;
    check("rf_c2", 8'(flush), 8'd1);
    @(negedge clk); #2;
    check("rf_c3", 8'(flush), 8'd1);
    @(negedge clk); #2;
    check("rf_c4", 8'(flush), 8'd0);

    // Reset while busy with cnt=2, error flagged and flush active
    @(negedge clk); lo_issue = 1; lo_rd = 9; lo_latency = 3;
    id_valid = 1; id_rs1 = 9; id_use_rs1 = 1; #2;
    @(negedge clk); br_mispredict = 1; #2;
    @(negedge clk); lo_issue = 0; br_mispredict = 0; rst = 1; #2;
    check("rmid_busy_in_rst", 8'(lo_busy), 8'd0);
    check("rmid_flush_in_rst", 8'(flush), 8'd0);
    check("rmid_stall_in_rst", 8'(stall), 8'd0);
    @(negedge clk); rst = 0; #2;
    check("rmid_busy", 8'(lo_busy), 8'd0);
    check("rmid_wb", 8'(lo_wb), 8'd0);
    check("rmid_err", 8'(proto_err), 8'd0);
    check("rmid_flush", 8'(flush), 8'd0);
    @(negedge clk); #2;
    check("rmid_wb_next", 8'(lo_wb), 8'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
